// File: rtl/box_motion_ctrl.sv
// Moves a box around the screen from four push buttons, one step per video frame,
// accelerating while a direction is held and clamping the box inside the visible area.
module box_motion_ctrl #(
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int BOX_W           = 100,
   parameter int BOX_H           = 100,
   parameter int START_X         = 270,
   parameter int START_Y         = 190,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int ACCEL_FRAMES    = 8,
   parameter int MAX_SPEED       = 4
) (
   input  logic       clk_25mhz,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       vsync,
   output logic [9:0] box_x,
   output logic [9:0] box_y,
   output logic [2:0] speed,
   output logic       frame_tick
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int ACC_W = $clog2(ACCEL_FRAMES + 1);
   localparam logic signed [11:0] X_LIM = 12'(SCREEN_W - BOX_W);
   localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H - BOX_H);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MOVE = 1'b1} state_t;

   // Bit order throughout: {right, left, down, up}.
   logic [3:0]      btn_raw_s;
   logic [3:0]      sync1_r, sync2_r, db_r;
   logic [DB_W-1:0] db_cnt_r [4];
   logic            vsync_prev_r, tick_s;

   state_t          state_r, state_nx_s;
   logic [9:0]      box_x_r, box_y_r, x_nx_s, y_nx_s;
   logic [2:0]      speed_r, spd_nx_s, step_spd_s, adv_spd_s;
   logic [ACC_W-1:0] acc_cnt_r, acc_nx_s, held_s, adv_acc_s;
   logic signed [11:0] dx_s, dy_s, step_s, new_x_s, new_y_s;
   logic            moving_s, frame_tick_r;

   function automatic logic [9:0] clamp_pos(input logic signed [11:0] p,
                                            input logic signed [11:0] lim);
      if (p < 12'sd0) begin
         return 10'd0;
      end else if (p > lim) begin
         return lim[9:0];
      end else begin
         return p[9:0];
      end
   endfunction

   assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up};
   assign tick_s    = vsync & ~vsync_prev_r;

   // Two-flop synchronizers for the raw buttons.
   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 4'd0;
         sync2_r <= 4'd0;
      end else begin
         sync1_r <= btn_raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Per-button debounce: flip only after a full run of disagreeing samples.
   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         db_r <= 4'd0;
         for (int i = 0; i < 4; i++) db_cnt_r[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] != db_r[i]) begin
               if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  db_r[i]     <= sync2_r[i];
                  db_cnt_r[i] <= '0;
               end else begin
                  db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
               end
            end else begin
               db_cnt_r[i] <= '0;
            end
         end
      end
   end

   // Next-state and next-position logic, evaluated only on a frame tick.
   always_comb begin
      state_nx_s = state_r;
      x_nx_s     = box_x_r;
      y_nx_s     = box_y_r;
      spd_nx_s   = speed_r;
      acc_nx_s   = acc_cnt_r;
      dx_s       = $signed({11'd0, db_r[3]}) - $signed({11'd0, db_r[2]});
      dy_s       = $signed({11'd0, db_r[1]}) - $signed({11'd0, db_r[0]});
      moving_s   = (dx_s != 12'sd0) || (dy_s != 12'sd0);
      // The tick that leaves IDLE is itself the first held frame at speed 1.
      step_spd_s = (state_r == ST_MOVE) ? speed_r : 3'd1;
      held_s     = (state_r == ST_MOVE) ? acc_cnt_r + ACC_W'(1) : ACC_W'(1);
      step_s     = $signed({9'd0, step_spd_s});
      new_x_s    = $signed({2'b00, box_x_r}) + dx_s * step_s;
      new_y_s    = $signed({2'b00, box_y_r}) + dy_s * step_s;
      if (held_s >= ACC_W'(ACCEL_FRAMES)) begin
         adv_acc_s = '0;
         adv_spd_s = (step_spd_s >= 3'(MAX_SPEED)) ? 3'(MAX_SPEED) : step_spd_s + 3'd1;
      end else begin
         adv_acc_s = held_s;
         adv_spd_s = step_spd_s;
      end
      if (tick_s) begin
         case (state_r)
            ST_IDLE: begin
               if (moving_s) begin
                  state_nx_s = ST_MOVE;
                  x_nx_s     = clamp_pos(new_x_s, X_LIM);
                  y_nx_s     = clamp_pos(new_y_s, Y_LIM);
                  spd_nx_s   = adv_spd_s;
                  acc_nx_s   = adv_acc_s;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_MOVE: begin
               if (moving_s) begin
                  state_nx_s = ST_MOVE;
                  x_nx_s     = clamp_pos(new_x_s, X_LIM);
                  y_nx_s     = clamp_pos(new_y_s, Y_LIM);
                  spd_nx_s   = adv_spd_s;
                  acc_nx_s   = adv_acc_s;
               end else begin
                  state_nx_s = ST_IDLE;
                  spd_nx_s   = 3'd0;
                  acc_nx_s   = '0;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
               spd_nx_s   = 3'd0;
               acc_nx_s   = '0;
            end
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Frame state registers; prev-vsync resets high so a high vsync at release is not an edge.
   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         vsync_prev_r <= 1'b1;
         frame_tick_r <= 1'b0;
         state_r      <= ST_IDLE;
         box_x_r      <= 10'(START_X);
         box_y_r      <= 10'(START_Y);
         speed_r      <= 3'd0;
         acc_cnt_r    <= '0;
      end else begin
         vsync_prev_r <= vsync;
         frame_tick_r <= tick_s;
         state_r      <= state_nx_s;
         box_x_r      <= x_nx_s;
         box_y_r      <= y_nx_s;
         speed_r      <= spd_nx_s;
         acc_cnt_r    <= acc_nx_s;
      end
   end

   assign box_x      = box_x_r;
   assign box_y      = box_y_r;
   assign speed      = speed_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Self-checking bench for box_motion_ctrl: directed scenarios plus random button
// segments, compared against a per-frame arithmetic reference model.
module tb_box_motion_ctrl;

   localparam int ACC   = 8;
   localparam int MAXS  = 4;
   localparam int XLIM  = 540;
   localparam int YLIM  = 380;

   logic       clk_25mhz, rst_n, btn_up, btn_down, btn_left, btn_right, vsync;
   logic [9:0] box_x, box_y;
   logic [2:0] speed;
   logic       frame_tick;

   int pass_cnt = 0;
   int total_cnt = 0;
   int mx, my, ms, mn;
   bit [3:0] mdb;   // {right, left, down, up} as the design should have debounced them

   box_motion_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk_25mhz(clk_25mhz), .rst_n(rst_n),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .vsync(vsync), .box_x(box_x), .box_y(box_y), .speed(speed), .frame_tick(frame_tick)
   );

   initial begin
      clk_25mhz = 1'b0;
      forever #20 clk_25mhz = ~clk_25mhz;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int obs, input int exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      else if (v > hi) return hi;
      else return v;
   endfunction

   function automatic int mini(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      mx = 270; my = 190; ms = 0; mn = 0; mdb = 4'd0;
   endtask

   // One frame: n consecutive held frames -> step used and speed reported.
   task automatic model_tick();
      int dx, dy, step;
      dx = int'(mdb[3]) - int'(mdb[2]);
      dy = int'(mdb[1]) - int'(mdb[0]);
      if (dx != 0 || dy != 0) begin
         mn++;
         step = mini(1 + (mn - 1) / ACC, MAXS);
         mx = clampi(mx + dx * step, XLIM);
         my = clampi(my + dy * step, YLIM);
         ms = mini(1 + mn / ACC, MAXS);
      end else begin
         mn = 0;
         ms = 0;
      end
   endtask

   // Called at posedge+1; leaves buttons stable long enough to be debounced.
   task automatic set_buttons(input bit [3:0] b);
      {btn_right, btn_left, btn_down, btn_up} = b;
      repeat (10) @(posedge clk_25mhz);
      #1;
      mdb = b;
   endtask

   task automatic do_tick();
      vsync = 1'b1;
      @(posedge clk_25mhz);
      #1;
      model_tick();
      check("tick_pulse", int'(frame_tick), 1);
      check("tick_x", int'(box_x), mx);
      check("tick_y", int'(box_y), my);
      check("tick_speed", int'(speed), ms);
      vsync = 1'b0;
      @(posedge clk_25mhz);
      #1;
      check("tick_end", int'(frame_tick), 0);
      check("hold_x", int'(box_x), mx);
   endtask

   initial begin
      int y_hold, guard, nt;
      bit [3:0] b;
      rst_n = 1'b0; vsync = 1'b1;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_25mhz);
      #1;
      check("rst_x", int'(box_x), 270);
      check("rst_y", int'(box_y), 190);
      check("rst_speed", int'(speed), 0);
      check("rst_tick", int'(frame_tick), 0);

      // Release with vsync already high: no frame tick.
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_25mhz);
         #1;
         check("no_tick_high_vsync", int'(frame_tick), 0);
      end
      check("idle_x", int'(box_x), 270);
      check("idle_y", int'(box_y), 190);
      vsync = 1'b0;
      @(posedge clk_25mhz);
      #1;

      // Right held for ten frames: eight at speed 1, two at speed 2.
      set_buttons(4'b1000);
      for (int i = 0; i < 10; i++) do_tick();
      check("accel_x", int'(box_x), 282);
      check("accel_speed", int'(speed), 2);

      // Opposing buttons cancel and drop back to IDLE.
      set_buttons(4'b1100);
      do_tick();
      check("oppose_x", int'(box_x), 282);
      check("oppose_speed", int'(speed), 0);

      // Left held into the edge; position must pin at zero.
      set_buttons(4'b0100);
      guard = 0;
      while (mx != 0 && guard < 200) begin
         do_tick();
         guard++;
      end
      check("clamp_reached", int'(guard < 200), 1);
      for (int i = 0; i < 3; i++) do_tick();
      check("clamp_x", int'(box_x), 0);
      check("clamp_speed", int'(speed), MAXS);

      // Short up glitch never gets through the debouncer.
      set_buttons(4'b0000);
      do_tick();
      y_hold = my;
      btn_up = 1'b1;
      repeat (3) @(posedge clk_25mhz);
      #1;
      btn_up = 1'b0;
      repeat (10) @(posedge clk_25mhz);
      #1;
      for (int i = 0; i < 3; i++) do_tick();
      check("glitch_y", int'(box_y), y_hold);

      // Random button segments.
      for (int s = 0; s < 6; s++) begin
         b = 4'($urandom_range(0, 15));
         set_buttons(b);
         nt = $urandom_range(1, 20);
         for (int i = 0; i < nt; i++) do_tick();
      end

      // Down held to speed 3, then reset mid-frame.
      set_buttons(4'b0000);
      do_tick();
      set_buttons(4'b0010);
      for (int i = 0; i < 16; i++) do_tick();
      check("down_speed", int'(speed), 3);
      @(posedge clk_25mhz);
      #8;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst_x", int'(box_x), 270);
      check("midrst_y", int'(box_y), 190);
      check("midrst_speed", int'(speed), 0);
      check("midrst_tick", int'(frame_tick), 0);
      @(negedge clk_25mhz);
      @(negedge clk_25mhz);
      rst_n = 1'b1;
      @(posedge clk_25mhz);
      #1;
      repeat (10) @(posedge clk_25mhz);
      #1;
      mdb = 4'b0010;
      do_tick();
      check("post_rst_y", int'(box_y), 191);
      check("post_rst_speed", int'(speed), 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
